// File: rtl/write_image_pkg.sv
// Shared definitions for the image-writer slice: FSM encoding and byte-layout constants.
package write_image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int BYTES_PER_PAIR  = 2 * BYTES_PER_PIXEL;

endpackage

// File: rtl/write_image_if.sv
// Pixel-pair stream in, frame-memory write port and status out.
interface write_image_if #(
  parameter int ADDR_WIDTH = 21
) ();

  logic                  vertical_Pulse;
  logic                  horizontal_Pulse;
  logic [7:0]            data_R_Even;
  logic [7:0]            data_G_Even;
  logic [7:0]            data_B_Even;
  logic [7:0]            data_R_Odd;
  logic [7:0]            data_G_Odd;
  logic [7:0]            data_B_Odd;
  logic                  mem_Write_Enable;
  logic [ADDR_WIDTH-1:0] mem_Address;
  logic [47:0]           mem_Data;
  logic                  done_Flag;
  logic                  frame_Error;

  modport master (
    output vertical_Pulse, horizontal_Pulse,
    output data_R_Even, data_G_Even, data_B_Even,
    output data_R_Odd, data_G_Odd, data_B_Odd,
    input  mem_Write_Enable, mem_Address, mem_Data, done_Flag, frame_Error
  );

  modport slave (
    input  vertical_Pulse, horizontal_Pulse,
    input  data_R_Even, data_G_Even, data_B_Even,
    input  data_R_Odd, data_G_Odd, data_B_Odd,
    output mem_Write_Enable, mem_Address, mem_Data, done_Flag, frame_Error
  );

endinterface

// File: rtl/write_image_addr_gen.sv
// Row/pair counters and bottom-up row-base tracking; produces the registered byte address.
module write_addr_gen
  import write_image_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  advance,
  output logic                  last_pair,
  output logic [ADDR_WIDTH-1:0] mem_addr
);

  localparam int PAIRS  = IMAGE_WIDTH / 2;
  localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH-1:0] ROW_BYTES =
    ADDR_WIDTH'(IMAGE_WIDTH * BYTES_PER_PIXEL);
  localparam logic [ADDR_WIDTH-1:0] TOP_BASE  =
    ADDR_WIDTH'((IMAGE_HEIGHT - 1) * IMAGE_WIDTH * BYTES_PER_PIXEL);
  localparam logic [ADDR_WIDTH-1:0] PAIR_STEP = ADDR_WIDTH'(BYTES_PER_PAIR);

  logic [PAIR_W-1:0]     pair_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] pair_off;
  logic                  row_end;

  assign row_end   = (pair_cnt == PAIR_W'(PAIRS - 1));
  assign last_pair = row_end && (row_cnt == ROW_W'(IMAGE_HEIGHT - 1));

  // Stage p1: address of the accepted pair; rows are written top row last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_cnt <= '0;
      row_cnt  <= '0;
      row_base <= TOP_BASE;
      pair_off <= '0;
      mem_addr <= '0;
    end else if (start) begin
      pair_cnt <= '0;
      row_cnt  <= '0;
      row_base <= TOP_BASE;
      pair_off <= '0;
    end else if (advance) begin
      mem_addr <= row_base + pair_off;
      if (row_end) begin
        pair_cnt <= '0;
        pair_off <= '0;
        row_cnt  <= row_cnt + 1'b1;
        row_base <= row_base - ROW_BYTES;
      end else begin
        pair_cnt <= pair_cnt + 1'b1;
        pair_off <= pair_off + PAIR_STEP;
      end
    end
  end

endmodule

// File: rtl/write_image.sv
// Image-stream sink: undoes the reader's row flip and emits 48-bit pair writes to frame memory.
module write_image
  import write_image_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 21
) (
  input logic          clk,
  input logic          reset,
  write_image_if.slave bus
);

  state_t                state_q, state_d;
  logic                  vp_p1;
  logic                  vp_rise;
  logic                  start, accept, set_done, set_err;
  logic                  last_pair;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  wr_vld_p1;
  logic [47:0]           wr_data_p1;
  logic                  done_q, err_q;

  function automatic logic [47:0] pack_pair(
    input logic [7:0] re, input logic [7:0] ge, input logic [7:0] be,
    input logic [7:0] ro, input logic [7:0] go, input logic [7:0] bo);
    return {re, ge, be, ro, go, bo};
  endfunction

  assign vp_rise = bus.vertical_Pulse && !vp_p1;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    accept   = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (vp_rise) begin
          state_d = ST_RECEIVE;
          start   = 1'b1;
        end
      end
      ST_RECEIVE: begin
        // A frame dropping before its last pair is an abort; a coincident strobe is discarded.
        if (!bus.vertical_Pulse) begin
          state_d = ST_IDLE;
          set_err = 1'b1;
        end else if (bus.horizontal_Pulse) begin
          accept = 1'b1;
          if (last_pair) begin
            state_d  = ST_DONE;
            set_done = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: control state, write strobe, pair data and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vp_p1      <= 1'b0;
      wr_vld_p1  <= 1'b0;
      wr_data_p1 <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      vp_p1     <= bus.vertical_Pulse;
      wr_vld_p1 <= accept;
      if (accept)
        wr_data_p1 <= pack_pair(bus.data_R_Even, bus.data_G_Even, bus.data_B_Even,
                                bus.data_R_Odd,  bus.data_G_Odd,  bus.data_B_Odd);
      if (start)
        done_q <= 1'b0;
      else if (set_done)
        done_q <= 1'b1;
      if (start)
        err_q <= 1'b0;
      else if (set_err)
        err_q <= 1'b1;
    end
  end

  write_addr_gen #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .advance   (accept),
    .last_pair (last_pair),
    .mem_addr  (addr_p1)
  );

  assign bus.mem_Write_Enable = wr_vld_p1;
  assign bus.mem_Address      = addr_p1;
  assign bus.mem_Data         = wr_data_p1;
  assign bus.done_Flag        = done_q;
  assign bus.frame_Error      = err_q;

endmodule
